// File: rtl/pll_refclk_supervisor.sv
`default_nettype none
// ============================================================================
// pll_refclk_supervisor: sequences PLL reference switchover, areset and lock
// qualification with bounded retries, in the clk27 domain.
// Revision: 1.0
// ============================================================================
module pll_refclk_supervisor #(
   parameter int ARESET_WIDTH  = 27,
   parameter int LOCK_TIMEOUT  = 270000,
   parameter int SETTLE_CYCLES = 2700,
   parameter int MAX_RETRY     = 3,
   parameter int WARN_WIDTH    = 24
) (
   input  logic       clk27,
   input  logic       reset,
   input  logic       sel_i,
   input  logic       reconfig_busy_i,
   input  logic       pll_activeclock_i,
   input  logic       pll_locked_i,
   output logic       pll_clkswitch_o,
   output logic       pll_areset_o,
   output logic       busy_o,
   output logic       locked_o,
   output logic       fail_o,
   output logic       warn_o,
   output logic [1:0] retry_cnt_o
);

   localparam int C_TW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [C_TW-1:0] c_areset_last  = C_TW'(ARESET_WIDTH - 1);
   localparam logic [C_TW-1:0] c_timeout_last = C_TW'(LOCK_TIMEOUT - 1);
   localparam logic [C_TW-1:0] c_settle_last  = C_TW'(SETTLE_CYCLES - 1);
   localparam logic [C_TW-1:0] c_timer_one    = C_TW'(1);
   localparam logic [1:0]      c_max_retry    = 2'(MAX_RETRY);
   localparam logic [WARN_WIDTH-1:0] c_warn_one = WARN_WIDTH'(1);

   typedef enum logic [2:0] {
      ST_ARESET      = 3'd0,
      ST_WAIT_LOCK   = 3'd1,
      ST_SETTLE      = 3'd2,
      ST_MONITOR     = 3'd3,
      ST_SWITCH      = 3'd4,
      ST_WAIT_ACTIVE = 3'd5,
      ST_FAIL        = 3'd6,
      ST_RECONF      = 3'd7
   } state_t;

   state_t                state_q, state_d;
   logic [C_TW-1:0]       timer_q, timer_d;
   logic [1:0]            retry_q, retry_d;
   logic [WARN_WIDTH-1:0] warn_cnt_q, warn_cnt_d;
   logic                  target_q, target_d;
   logic                  sel_fail_q, sel_fail_d;
   logic                  act_meta_q, act_meta_d, act_s_q, act_s_d;
   logic                  lock_meta_q, lock_meta_d, lock_s_q, lock_s_d;
   logic                  areset_q, areset_d;
   logic                  clkswitch_q, clkswitch_d;
   logic                  busy_q, busy_d;
   logic                  locked_q, locked_d;
   logic                  fail_q, fail_d;
   logic                  warn_q, warn_d;
   logic [1:0]            retry_inc;
   logic                  warn_load;

   always_comb begin
      act_meta_d  = pll_activeclock_i;
      act_s_d     = act_meta_q;
      lock_meta_d = pll_locked_i;
      lock_s_d    = lock_meta_q;
      state_d     = state_q;
      target_d    = target_q;
      sel_fail_d  = sel_fail_q;
      retry_d     = retry_q;
      warn_load   = 1'b0;
      retry_inc   = retry_q + 2'd1;

      // pll_reconfig owns the PLL while busy; nothing else may move the FSM
      if (reconfig_busy_i) begin
         state_d = ST_RECONF;
      end else begin
         case (state_q)
            ST_ARESET: begin
               if (timer_q == c_areset_last) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (lock_s_q) begin
                  state_d = ST_SETTLE;
               end else if (timer_q == c_timeout_last) begin
                  retry_d = retry_inc;
                  state_d = (retry_inc == c_max_retry) ? ST_FAIL : ST_ARESET;
               end
            end
            ST_SETTLE: begin
               if (!lock_s_q) begin
                  state_d = ST_WAIT_LOCK;
               end else if (timer_q == c_settle_last) begin
                  state_d = ST_MONITOR;
                  retry_d = 2'd0;
               end
            end
            ST_MONITOR: begin
               // a lock loss still raises the warning even when a switch wins
               if (!lock_s_q) warn_load = 1'b1;
               if (sel_i != act_s_q) begin
                  target_d = sel_i;
                  state_d  = ST_SWITCH;
               end else if (!lock_s_q) begin
                  state_d = ST_WAIT_LOCK;
               end
            end
            ST_SWITCH: begin
               state_d = ST_WAIT_ACTIVE;
            end
            ST_WAIT_ACTIVE: begin
               if (act_s_q == target_q) begin
                  state_d = ST_ARESET;
               end else if (timer_q == c_timeout_last) begin
                  retry_d = retry_inc;
                  state_d = (retry_inc == c_max_retry) ? ST_FAIL : ST_SWITCH;
               end
            end
            ST_FAIL: begin
               if (sel_i != sel_fail_q) begin
                  retry_d  = 2'd0;
                  target_d = sel_i;
                  state_d  = (act_s_q != sel_i) ? ST_SWITCH : ST_ARESET;
               end
            end
            ST_RECONF: begin
               state_d = ST_WAIT_LOCK;
               retry_d = 2'd0;
            end
            default: begin
               state_d = ST_ARESET;
            end
         endcase
      end

      if ((state_d == ST_FAIL) && (state_q != ST_FAIL)) begin
         warn_load  = 1'b1;
         sel_fail_d = sel_i;
      end

      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q == '1) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + c_timer_one;
      end

      if (warn_load) begin
         warn_cnt_d = '1;
      end else if (warn_cnt_q != '0) begin
         warn_cnt_d = warn_cnt_q - c_warn_one;
      end else begin
         warn_cnt_d = warn_cnt_q;
      end

      // outputs decoded from the next state so the registered copies track it
      areset_d    = (state_d == ST_ARESET);
      clkswitch_d = (state_d == ST_SWITCH);
      locked_d    = (state_d == ST_MONITOR);
      fail_d      = (state_d == ST_FAIL);
      busy_d      = !((state_d == ST_MONITOR) || (state_d == ST_FAIL));
      warn_d      = (warn_cnt_d != '0);
   end

   always_ff @(posedge clk27) begin
      if (reset) begin
         state_q     <= ST_ARESET;
         timer_q     <= '0;
         retry_q     <= 2'd0;
         warn_cnt_q  <= '0;
         target_q    <= 1'b0;
         sel_fail_q  <= 1'b0;
         act_meta_q  <= 1'b0;
         act_s_q     <= 1'b0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         areset_q    <= 1'b1;
         clkswitch_q <= 1'b0;
         busy_q      <= 1'b1;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
         warn_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         warn_cnt_q  <= warn_cnt_d;
         target_q    <= target_d;
         sel_fail_q  <= sel_fail_d;
         act_meta_q  <= act_meta_d;
         act_s_q     <= act_s_d;
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
         areset_q    <= areset_d;
         clkswitch_q <= clkswitch_d;
         busy_q      <= busy_d;
         locked_q    <= locked_d;
         fail_q      <= fail_d;
         warn_q      <= warn_d;
      end
   end

   assign pll_areset_o    = areset_q;
   assign pll_clkswitch_o = clkswitch_q;
   assign busy_o          = busy_q;
   assign locked_o        = locked_q;
   assign fail_o          = fail_q;
   assign warn_o          = warn_q;
   assign retry_cnt_o     = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_refclk_supervisor.sv
`default_nettype none
// Directed bench for pll_refclk_supervisor with small timing parameters;
// every expected cycle count below is derived by hand from the sequencing rules.
module tb_pll_refclk_supervisor;

   logic       clk27 = 1'b0;
   logic       reset;
   logic       sel_i;
   logic       reconfig_busy_i;
   logic       pll_activeclock_i;
   logic       pll_locked_i;
   logic       pll_clkswitch_o;
   logic       pll_areset_o;
   logic       busy_o;
   logic       locked_o;
   logic       fail_o;
   logic       warn_o;
   logic [1:0] retry_cnt_o;

   int n_vec = 0;
   int n_err = 0;
   int n_ar  = 0;
   int n_sw  = 0;
   int n     = 0;

   always #5 clk27 = ~clk27;

   pll_refclk_supervisor #(
      .ARESET_WIDTH  (4),
      .LOCK_TIMEOUT  (100),
      .SETTLE_CYCLES (10),
      .MAX_RETRY     (3),
      .WARN_WIDTH    (8)
   ) u_dut (
      .clk27             (clk27),
      .reset             (reset),
      .sel_i             (sel_i),
      .reconfig_busy_i   (reconfig_busy_i),
      .pll_activeclock_i (pll_activeclock_i),
      .pll_locked_i      (pll_locked_i),
      .pll_clkswitch_o   (pll_clkswitch_o),
      .pll_areset_o      (pll_areset_o),
      .busy_o            (busy_o),
      .locked_o          (locked_o),
      .fail_o            (fail_o),
      .warn_o            (warn_o),
      .retry_cnt_o       (retry_cnt_o)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // advance n clock edges, sampling 1 ns after each edge
   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk27);
         #1;
         if (pll_areset_o)    n_ar++;
         if (pll_clkswitch_o) n_sw++;
      end
   endtask

   task automatic wait_locked(input int budget, output int cycles);
      cycles = 0;
      while (!locked_o && cycles < budget) begin
         run(1);
         cycles++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset             = 1'b1;
      sel_i             = 1'b0;
      reconfig_busy_i   = 1'b0;
      pll_activeclock_i = 1'b0;
      pll_locked_i      = 1'b0;
      run(3);
      reset = 1'b0;

      // reset values
      chk("rst_areset",    int'(pll_areset_o),    1);
      chk("rst_busy",      int'(busy_o),          1);
      chk("rst_clkswitch", int'(pll_clkswitch_o), 0);
      chk("rst_locked",    int'(locked_o),        0);
      chk("rst_fail",      int'(fail_o),          0);
      chk("rst_warn",      int'(warn_o),          0);
      chk("rst_retry",     int'(retry_cnt_o),     0);

      // power-up: areset 4 cycles, lock at +20, locked_o at +33
      n = 0;
      while (pll_areset_o && n < 50) begin
         n++;
         run(1);
      end
      chk("pwr_areset_len", n, 4);
      run(16);
      pll_locked_i = 1'b1;
      run(12);
      chk("pwr_locked_early", int'(locked_o), 0);
      run(1);
      chk("pwr_locked",  int'(locked_o),    1);
      chk("pwr_busy",    int'(busy_o),      0);
      chk("pwr_retry",   int'(retry_cnt_o), 0);

      // switchover to TVP_PCLK, activeclock follows 5 cycles after the pulse
      sel_i = 1'b1;
      n_ar  = 0;
      n_sw  = 0;
      run(1);
      chk("sw_pulse",       int'(pll_clkswitch_o), 1);
      chk("sw_locked_drop", int'(locked_o),        0);
      run(5);
      pll_activeclock_i = 1'b1;
      wait_locked(100, n);
      chk("sw_relock_cycles", n,    18);
      chk("sw_pulse_count",   n_sw, 1);
      chk("sw_areset_len",    n_ar, 4);

      // lock lost in MONITOR
      pll_locked_i = 1'b0;
      run(2);
      chk("ll_still_locked", int'(locked_o), 1);
      run(1);
      chk("ll_locked_drop", int'(locked_o), 0);
      chk("ll_warn_set",    int'(warn_o),   1);
      n_ar = 0;
      run(10);
      pll_locked_i = 1'b1;
      run(12);
      chk("ll_relock_early", int'(locked_o), 0);
      run(1);
      chk("ll_relocked",  int'(locked_o), 1);
      chk("ll_no_areset", n_ar,           0);
      run(231);
      chk("ll_warn_last", int'(warn_o), 1);
      run(1);
      chk("ll_warn_clear", int'(warn_o), 0);

      // glitch during SETTLE forces a full settle again
      pll_locked_i = 1'b0;
      run(3);
      chk("gl_unlocked", int'(locked_o), 0);
      pll_locked_i = 1'b1;
      run(9);
      chk("gl_in_settle", int'(locked_o), 0);
      pll_locked_i = 1'b0;
      n_ar = 0;
      run(4);
      pll_locked_i = 1'b1;
      run(12);
      chk("gl_settle_early", int'(locked_o), 0);
      run(1);
      chk("gl_locked",    int'(locked_o),    1);
      chk("gl_no_areset", n_ar,              0);
      chk("gl_retry",     int'(retry_cnt_o), 0);

      // mismatch and lock loss in the same cycle
      run(230);
      chk("pri_warn_idle", int'(warn_o), 0);
      pll_locked_i = 1'b0;
      run(2);
      sel_i = 1'b0;
      run(1);
      chk("pri_switch_taken", int'(pll_clkswitch_o), 1);
      chk("pri_warn_set",     int'(warn_o),          1);
      chk("pri_locked_drop",  int'(locked_o),        0);
      pll_activeclock_i = 1'b0;
      pll_locked_i      = 1'b1;
      wait_locked(100, n);
      chk("pri_recover", int'(locked_o), 1);

      // reset mid-operation
      pll_locked_i = 1'b0;
      reset        = 1'b1;
      run(1);
      chk("mid_rst_areset", int'(pll_areset_o), 1);
      chk("mid_rst_busy",   int'(busy_o),       1);
      chk("mid_rst_locked", int'(locked_o),     0);
      chk("mid_rst_warn",   int'(warn_o),       0);
      run(1);
      reset = 1'b0;
      n_ar  = 0;

      // lock never arrives: three attempts then FAIL
      run(103);
      chk("to_areset_gap",  int'(pll_areset_o), 0);
      chk("to_retry0",      int'(retry_cnt_o),  0);
      chk("to_first_pulse", n_ar,               3);
      run(1);
      chk("to_areset2", int'(pll_areset_o), 1);
      chk("to_retry1",  int'(retry_cnt_o),  1);
      run(104);
      chk("to_areset3", int'(pll_areset_o), 1);
      chk("to_retry2",  int'(retry_cnt_o),  2);
      run(103);
      chk("to_fail_early", int'(fail_o), 0);
      run(1);
      chk("to_fail",        int'(fail_o),       1);
      chk("to_retry3",      int'(retry_cnt_o),  3);
      chk("to_fail_areset", int'(pll_areset_o), 0);
      chk("to_fail_busy",   int'(busy_o),       0);
      chk("to_fail_warn",   int'(warn_o),       1);
      chk("to_areset_total", n_ar,              11);
      run(254);
      chk("to_warn_last", int'(warn_o), 1);
      run(1);
      chk("to_warn_clear", int'(warn_o), 0);
      sel_i = 1'b1;
      run(1);
      chk("fx_switch", int'(pll_clkswitch_o), 1);
      chk("fx_retry",  int'(retry_cnt_o),     0);
      chk("fx_fail",   int'(fail_o),          0);
      chk("fx_busy",   int'(busy_o),          1);

      // WAIT_ACTIVE timeout retries the switch, then reconfig takes over
      run(101);
      chk("wa_reswitch", int'(pll_clkswitch_o), 1);
      chk("wa_retry1",   int'(retry_cnt_o),     1);
      run(6);
      reconfig_busy_i = 1'b1;
      n_ar = 0;
      n_sw = 0;
      run(6);
      chk("rc_no_switch", n_sw,           0);
      chk("rc_no_areset", n_ar,           0);
      chk("rc_busy",      int'(busy_o),   1);
      chk("rc_locked",    int'(locked_o), 0);
      reconfig_busy_i = 1'b0;
      run(1);
      chk("rc_retry_clr", int'(retry_cnt_o),     0);
      chk("rc_rel_busy",  int'(busy_o),          1);
      chk("rc_rel_sw",    int'(pll_clkswitch_o), 0);
      run(1);
      chk("rc_wait_lock", int'(pll_areset_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
